// File: rtl/finv_table_loader_if.sv
// Byte-stream link into finv_table_loader (e.g. from the UART receiver).
// Handshake: a byte transfers on every rising clk edge where in_valid && in_ready;
// in_data must be stable while in_valid is high, and in_ready never depends on in_valid.
interface finv_table_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/finv_table_loader.sv
// Runtime loader for the finv reciprocal seed/slope table: 5 bytes per entry, written in order.
// Optional trailing XOR checksum byte is enabled by defining FINV_TABLE_LOADER_CSUM_EN.
module finv_table_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  finv_table_loader_if.slave     stream,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CSUM = 2'd2, FIN = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [2:0]            byte_cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-9:0]     asm_q;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  ready;
  logic                  accept;
  logic                  last_byte;
  logic                  load_clear;
  logic                  we;

  // Ready is a pure function of state so the upstream source can rely on it.
  assign ready     = (state_q == LOAD) || (state_q == CSUM);
  assign accept    = stream.in_valid && ready && !rst;
  assign last_byte = (addr_q == {ADDR_W{1'b1}}) && (byte_cnt_q == 3'd4);
  assign we        = (state_q == LOAD) && accept && (byte_cnt_q == 3'd4);

  assign stream.in_ready = ready;
  assign busy            = ready;
  assign done            = (state_q == FIN);
  assign state_dbg       = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_clear = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d    = LOAD;
          load_clear = 1'b1;
        end
      end
      LOAD: begin
        if (accept && last_byte) begin
`ifdef FINV_TABLE_LOADER_CSUM_EN
          state_d = CSUM;
`else
          state_d = FIN;
`endif
        end
      end
      CSUM: begin
        if (accept) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bytes 0-3 are assembled big-endian; byte 4 goes straight into the RAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= 3'd0;
      addr_q     <= '0;
      asm_q      <= '0;
    end else if (load_clear) begin
      byte_cnt_q <= 3'd0;
      addr_q     <= '0;
    end else if ((state_q == LOAD) && accept) begin
      case (byte_cnt_q)
        3'd0:    asm_q[27:24] <= stream.in_data[3:0];
        3'd1:    asm_q[23:16] <= stream.in_data;
        3'd2:    asm_q[15:8]  <= stream.in_data;
        3'd3:    asm_q[7:0]   <= stream.in_data;
        default: ;
      endcase
      if (byte_cnt_q == 3'd4) begin
        byte_cnt_q <= 3'd0;
        addr_q     <= addr_q + ADDR_W'(1);
      end else begin
        byte_cnt_q <= byte_cnt_q + 3'd1;
      end
    end
  end

  // RAM is not reset; a read colliding with a write returns the old entry.
  always_ff @(posedge clk) begin
    if (we) mem[addr_q] <= {asm_q, stream.in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef FINV_TABLE_LOADER_CSUM_EN
  logic [7:0] csum_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (rst || load_clear) begin
      csum_q <= 8'd0;
      err_q  <= 1'b0;
    end else if ((state_q == LOAD) && accept) begin
      csum_q <= csum_q ^ stream.in_data;
    end else if ((state_q == CSUM) && accept) begin
      err_q <= (stream.in_data != csum_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
